spi_reg_controller: RTL
=======================

Name: spi_reg_controller

Overview:
SPI controller (initiator) that drives the 3-wire write interface of the team's SPI register peripheral (SCLK, COPI, nCS). It accepts one register request at a time over a valid/ready handshake and serialises it as a 16-bit mode-0 frame, MSB first: {rw, addr[6:0], data[7:0]}. It is used as the bench/bring-up driver and as the on-chip master when a second tile configures the PWM peripheral's registers.

Parameters:
CLK_DIV, 4, system clocks per SCLK half-period (legal range >= 2; elaboration error below 2)
CS_SETUP, 2, clocks between nCS falling and the first SCLK rising edge's low phase (>= 1)
CS_HOLD, 2, clocks nCS stays low after the last SCLK falling edge (>= 1)
CS_IDLE, 2, minimum clocks nCS stays high before the next frame may be accepted (>= 1)

Ports:
clk  input  1  system clock; all logic on the rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_rw  input  1  frame bit 15: 1 = write, 0 = read (peripheral ignores reads)
req_addr  input  7  register address, frame bits 14:8
req_data  input  8  register data, frame bits 7:0
busy  output  1  high from accept until return to IDLE
done  output  1  one-cycle pulse when a frame completes
SCLK  output  1  SPI clock, idle low (CPOL=0)
COPI  output  1  serial data, changes while SCLK is low (CPHA=0)
nCS  output  1  chip select, active low

Behaviour:
- Clock is clk; reset is rst_n, asynchronous, active-low. All outputs are registered.
- Reset values: nCS=1, SCLK=0, COPI=0, busy=0, done=0, req_ready=0 while rst_n=0; req_ready=1 from the first cycle after reset release.
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE: req_ready=1, nCS=1, SCLK=0, COPI=0. If req_valid=1 at a rising edge, latch the frame {req_rw, req_addr, req_data} into a 16-bit shift register, set busy=1, and move to SETUP. Inputs are sampled only on the accept edge.
- SETUP: nCS=0, SCLK=0, COPI=frame[15]. Lasts CS_SETUP cycles, then moves to SHIFT.
- SHIFT: 16 bits. Each bit is CLK_DIV cycles with SCLK=0, then CLK_DIV cycles with SCLK=1. COPI holds the current bit for the whole bit period. COPI advances to the next bit on the cycle SCLK returns low. Exactly 16 rising edges are produced. After the 16th high phase, SCLK goes low and the state moves to HOLD.
- HOLD: nCS=0, SCLK=0, COPI holds frame[0]. Lasts CS_HOLD cycles.
- GAP: nCS=1, COPI=0, done=1 for the first GAP cycle only, req_ready=0. Lasts CS_IDLE cycles, then moves to IDLE, where busy=0.
- Timing: nCS is low for exactly CS_SETUP + 32*CLK_DIV + CS_HOLD cycles (132 with defaults). Between frames, nCS is high for at least CS_IDLE + 1 cycles.
- req_valid outside IDLE is ignored; no request is queued. req_ready is never high in the same cycle as done.
- A counter sized for max(CLK_DIV, CS_SETUP, CS_HOLD, CS_IDLE) times phases. A 5-bit bit counter counts 0..15; it has no wrap-around beyond 16.
- Reset asserted mid-frame: outputs return to reset values immediately (asynchronously). The frame is abandoned, no done is produced, and the next accepted request sends a complete frame.

Test Plan:
1. Reset, then request rw=1, addr=0x00, data=0xFF -> COPI sampled on SCLK rising edges reads 1000_0000_1111_1111; exactly 16 rising edges; nCS low for 132 cycles; one done pulse as nCS rises; busy low CS_IDLE cycles later.
2. req_valid held high with two queued requests (addr 0x01/data 0xA5, then addr 0x02/data 0x3C) -> two complete frames; nCS high >= 3 cycles between them; second frame data equals 0x3C.
3. Request rw=0, addr=0x04, data=0x80 -> first bit is 0; frame 0000_0100_1000_0000; timing identical to scenario 1.
4. Assert rst_n low after the 5th SCLK rising edge -> nCS=1, SCLK=0, COPI=0 in the same cycle; no done. After release, request addr=0x03/data=0x11 -> full 16-bit frame is correct.
5. During busy, drive req_valid=1 with addr=0x7F/data=0x00 for 50 cycles -> req_ready stays 0; the in-flight frame is unchanged; the stray request is not sent once that frame ends unless req_valid is still high in IDLE.
6. Loopback into the spi_peripheral + pwm_peripheral top level with CLK_DIV=4: write 0xFF to addrs 0x00-0x03 and 0x80 to addr 0x04 -> all 16 outputs toggle at a 50% duty cycle.

Source files
------------

// File: rtl/spi_reg_controller_if.sv
// Request handshake between a register-write requester and spi_reg_controller.
interface spi_reg_controller_if;
   logic       req_valid;
   logic       req_ready;
   logic       req_rw;
   logic [6:0] req_addr;
   logic [7:0] req_data;

   modport master (output req_valid, req_rw, req_addr, req_data, input req_ready);
   modport slave  (input req_valid, req_rw, req_addr, req_data, output req_ready);
endinterface

// File: rtl/spi_reg_controller.sv
// SPI mode-0 initiator: serialises {rw, addr[6:0], data[7:0]} MSB first with
// programmable chip-select setup/hold/idle spacing and SCLK half-period.
module spi_reg_controller #(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned CS_SETUP = 2,
   parameter int unsigned CS_HOLD  = 2,
   parameter int unsigned CS_IDLE  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   spi_reg_controller_if.slave  req,
   output logic                 busy,
   output logic                 done,
   output logic                 SCLK,
   output logic                 COPI,
   output logic                 nCS
);

   localparam int unsigned MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
   localparam int unsigned MAX_B   = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
   localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int unsigned BIT_W   = 5;
   localparam int unsigned FRAME_W = 16;

   // Reject parameter values that would break the frame timing
   if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("spi_reg_controller: CLK_DIV must be >= 2");
   end
   if (CS_SETUP < 1 || CS_HOLD < 1 || CS_IDLE < 1) begin : g_bad_cs
      $error("spi_reg_controller: CS_SETUP, CS_HOLD and CS_IDLE must be >= 1");
   end

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_SHIFT = 3'd2,
      S_HOLD  = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   state_t               state, state_d;
   logic [CNT_W-1:0]     cnt, cnt_d;
   logic [BIT_W-1:0]     bit_cnt, bit_cnt_d;
   logic                 sclk_q, sclk_d;
   logic [FRAME_W-1:0]   shreg, shreg_d;

   logic                 ncs_d, copi_d, busy_d, done_d, ready_d;
   logic                 ready_q;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         sclk_q  <= 1'b0;
         shreg   <= '0;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         bit_cnt <= bit_cnt_d;
         sclk_q  <= sclk_d;
         shreg   <= shreg_d;
      end
   end

   // Next-state, phase counter, bit counter and shift register update
   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      bit_cnt_d = bit_cnt;
      sclk_d    = sclk_q;
      shreg_d   = shreg;
      unique case (state)
         S_IDLE: begin
            sclk_d = 1'b0;
            if (req.req_valid && ready_q) begin
               state_d = S_SETUP;
               cnt_d   = '0;
               shreg_d = {req.req_rw, req.req_addr, req.req_data};
            end
         end
         S_SETUP: begin
            if (cnt == CNT_W'(CS_SETUP - 1)) begin
               state_d   = S_SHIFT;
               cnt_d     = '0;
               bit_cnt_d = '0;
               sclk_d    = 1'b0;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         S_SHIFT: begin
            if (cnt == CNT_W'(CLK_DIV - 1)) begin
               cnt_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
                  // last high phase done: keep frame[0] on COPI through HOLD
                  sclk_d  = 1'b0;
                  state_d = S_HOLD;
               end else begin
                  sclk_d    = 1'b0;
                  bit_cnt_d = bit_cnt + BIT_W'(1);
                  shreg_d   = {shreg[FRAME_W-2:0], 1'b0};
               end
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         S_HOLD: begin
            if (cnt == CNT_W'(CS_HOLD - 1)) begin
               state_d = S_GAP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         S_GAP: begin
            if (cnt == CNT_W'(CS_IDLE - 1)) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            sclk_d  = 1'b0;
         end
      endcase
   end

   // Output values for the upcoming cycle, derived from the next state
   always_comb begin
      ncs_d   = 1'b1;
      copi_d  = 1'b0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      ready_d = 1'b0;
      unique case (state_d)
         S_IDLE: begin
            busy_d  = 1'b0;
            ready_d = 1'b1;
         end
         S_SETUP, S_SHIFT, S_HOLD: begin
            ncs_d  = 1'b0;
            copi_d = shreg_d[FRAME_W-1];
         end
         S_GAP: begin
            done_d = (state == S_HOLD);
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   // Output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nCS     <= 1'b1;
         COPI    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         nCS     <= ncs_d;
         COPI    <= copi_d;
         busy    <= busy_d;
         done    <= done_d;
         ready_q <= ready_d;
      end
   end

   assign SCLK          = sclk_q;
   assign req.req_ready = ready_q;

endmodule
